tex_rsp_arb: RTL

TEX_RSP_ARB -- requirements
Module: tex_rsp_arb

---
 rtl/tex_rsp_arb.sv | 81 ++++++++
 1 files changed

// File: rtl/tex_rsp_arb.sv
// tex_rsp_arb: round-robin merge of texture response channels into a 2-entry in-order output buffer
module tex_rsp_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_LANES  = 4,
    parameter int TAG_WIDTH  = 8,
    localparam int SEL_BITS  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int OUT_TAG_W = TAG_WIDTH + SEL_BITS
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_INPUTS-1:0]                      in_valid,
    input  logic [NUM_INPUTS-1:0][NUM_LANES*32-1:0]    in_texels,
    input  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]       in_tag,
    output logic [NUM_INPUTS-1:0]                      in_ready,
    output logic                                       out_valid,
    output logic [NUM_LANES*32-1:0]                    out_texels,
    output logic [OUT_TAG_W-1:0]                       out_tag,
    input  logic                                       out_ready
);
    localparam int TEX_W = NUM_LANES * 32;
    localparam int ENT_W = TEX_W + OUT_TAG_W;
    localparam logic [SEL_BITS-1:0] LAST = SEL_BITS'(NUM_INPUTS - 1);

    logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d, grant_idx;
    logic [1:0]          count_q, count_d;
    logic [ENT_W-1:0]    buf_q [2];
    logic [ENT_W-1:0]    buf_d [2];
    logic                grant_valid, in_fire, out_fire, wr_slot;

    function automatic logic [SEL_BITS-1:0] wrap_add(input logic [SEL_BITS-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return SEL_BITS'((s >= NUM_INPUTS) ? s - NUM_INPUTS : s);
    endfunction

    // Scan offsets from farthest to nearest so the last hit is the first valid channel at/after rr_ptr
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (in_valid[wrap_add(rr_ptr_q, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // Handshakes: only the granted channel sees ready, and only while a slot is free; all quiet in reset
    always_comb begin
        in_fire   = grant_valid && (count_q != 2'd2) && !reset;
        in_ready  = '0;
        if (in_fire) in_ready[grant_idx] = 1'b1;
        out_valid = (count_q != 2'd0) && !reset;
        out_fire  = out_valid && out_ready;
    end

    // Slot 0 always holds the oldest entry; a pop shifts slot 1 down before the push lands behind it
    always_comb begin
        wr_slot = count_q[0] & ~out_fire;
        buf_d   = buf_q;
        if (out_fire) buf_d[0] = buf_q[1];
        if (in_fire) buf_d[wr_slot] = {in_texels[grant_idx], grant_idx, in_tag[grant_idx]};
        count_d  = count_q + {1'b0, in_fire} - {1'b0, out_fire};
        rr_ptr_d = in_fire ? ((grant_idx == LAST) ? '0 : grant_idx + 1'b1) : rr_ptr_q;
    end

    // Control state resets; payload slots are only meaningful under count so they need no reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
        buf_q <= buf_d;
    end

    assign out_texels = buf_q[0][ENT_W-1 -: TEX_W];
    assign out_tag    = buf_q[0][OUT_TAG_W-1:0];
endmodule
